// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: loads a word and shifts it one bit per clock.
// Define SHIFT_SEQ_ROTATE_EN to build the ROL/ROR modes.
module shift_sequencer #(
    parameter int LENGTH = 16,
    parameter int AMT_W  = $clog2(LENGTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [AMT_W-1:0]  amount,
    input  logic              bin,
    input  logic [LENGTH-1:0] ins,
    output logic [LENGTH-1:0] shifted_out,
    output logic              carry_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [LENGTH-1:0] data;
    logic [LENGTH-1:0] data_n;
    logic              carry;
    logic              carry_n;
    logic [AMT_W-1:0]  cnt;
    logic [AMT_W-1:0]  cnt_n;
    logic [2:0]        mode_q;
    logic [2:0]        mode_n;
    logic [LENGTH-1:0] step_data;
    logic              step_carry;

    // One single-bit step of the latched mode; unused codes fall to SLL
    always_comb begin
        step_data  = {data[LENGTH-2:0], bin};
        step_carry = data[LENGTH-1];
        case (mode_q)
            3'd1: begin
                step_data  = {bin, data[LENGTH-1:1]};
                step_carry = data[0];
            end
            3'd2: begin
                step_data  = {data[LENGTH-1], data[LENGTH-1:1]};
                step_carry = data[0];
            end
`ifdef SHIFT_SEQ_ROTATE_EN
            3'd3: begin
                step_data  = {data[LENGTH-2:0], data[LENGTH-1]};
                step_carry = data[LENGTH-1];
            end
            3'd4: begin
                step_data  = {data[0], data[LENGTH-1:1]};
                step_carry = data[0];
            end
`else
            3'd4: begin
                step_data  = {bin, data[LENGTH-1:1]};
                step_carry = data[0];
            end
`endif
            default: begin
                step_data  = {data[LENGTH-2:0], bin};
                step_carry = data[LENGTH-1];
            end
        endcase
    end

    // Next-state, datapath update and status outputs
    always_comb begin
        state_n = state;
        data_n  = data;
        carry_n = carry;
        cnt_n   = cnt;
        mode_n  = mode_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            SHIFT: begin
                busy    = 1'b1;
                data_n  = step_data;
                carry_n = step_carry;
                cnt_n   = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            IDLE, DONE: begin
                done    = (state == DONE);
                state_n = IDLE;
                if (start) begin
                    data_n  = ins;
                    cnt_n   = amount;
                    mode_n  = mode;
                    carry_n = 1'b0;
                    state_n = (amount != '0) ? SHIFT : DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            mode_q <= 3'd0;
        end else begin
            state  <= state_n;
            data   <= data_n;
            carry  <= carry_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
        end
    end

    assign shifted_out = data;
    assign carry_out   = carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer at LENGTH=8.
// Expectations follow SHIFT_SEQ_ROTATE_EN when it is defined.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic       bin;
    logic [7:0] ins;
    logic [7:0] shifted_out;
    logic       carry_out;
    logic       busy;
    logic       done;

    int total;
    int passed;
    int lat;
    int busy_cnt;
    int done_cnt;
    int overlap;

    shift_sequencer #(.LENGTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .amount      (amount),
        .bin         (bin),
        .ins         (ins),
        .shifted_out (shifted_out),
        .carry_out   (carry_out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done
    task automatic run_op(input logic [2:0] m, input logic [7:0] d,
                          input logic [3:0] a, input logic b,
                          input int inject_at);
        mode   = m;
        ins    = d;
        amount = a;
        bin    = b;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (lat == inject_at) begin
                start  = 1'b1;
                ins    = 8'h00;
                amount = 4'd0;
                mode   = 3'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        if (busy && done) overlap++;
        if (lat >= 40) check("timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        overlap  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 3'd0;
        amount   = 4'd0;
        bin      = 1'b0;
        ins      = 8'h00;
        tick();
        start = 1'b1;
        ins   = 8'hFF;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_data", 32'(shifted_out), 32'h00);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();

        // SLL 0x96 by 3, bin=1
        run_op(3'd0, 8'h96, 4'd3, 1'b1, -1);
        check("sll_data", 32'(shifted_out), 32'hB7);
        check("sll_carry", 32'(carry_out), 32'd0);
        check("sll_busy", 32'(busy_cnt), 32'd3);
        check("sll_lat", 32'(lat), 32'd3);
        tick();
        check("sll_pulse", 32'(done), 32'd0);
        check("sll_hold", 32'(shifted_out), 32'hB7);

        // SRA 0xA4 by 2
        run_op(3'd2, 8'hA4, 4'd2, 1'b0, -1);
        check("sra_data", 32'(shifted_out), 32'hE9);
        check("sra_carry", 32'(carry_out), 32'd0);
        check("sra_lat", 32'(lat), 32'd2);
        tick();

        // ROR 0x81 by 1
        run_op(3'd4, 8'h81, 4'd1, 1'b0, -1);
`ifdef SHIFT_SEQ_ROTATE_EN
        check("ror_data", 32'(shifted_out), 32'hC0);
`else
        check("ror_data", 32'(shifted_out), 32'h40);
`endif
        check("ror_carry", 32'(carry_out), 32'd1);
        tick();

        // Unused code 7 behaves as SLL
        run_op(3'd7, 8'h80, 4'd1, 1'b0, -1);
        check("m7_data", 32'(shifted_out), 32'h00);
        check("m7_carry", 32'(carry_out), 32'd1);
        tick();

        // Zero amount
        run_op(3'd0, 8'h5A, 4'd0, 1'b1, -1);
        check("zero_data", 32'(shifted_out), 32'h5A);
        check("zero_carry", 32'(carry_out), 32'd0);
        check("zero_lat", 32'(lat), 32'd0);
        check("zero_busy", 32'(busy_cnt), 32'd0);
        tick();

        // Over-length SRL with an ignored start during SHIFT
        run_op(3'd1, 8'hFF, 4'd10, 1'b0, 3);
        check("ovr_data", 32'(shifted_out), 32'h00);
        check("ovr_busy", 32'(busy_cnt), 32'd10);
        check("ovr_lat", 32'(lat), 32'd10);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("ovr_one_done", 32'(done_cnt), 32'd0);
        check("ovr_hold", 32'(shifted_out), 32'h00);

        // Reset during cycle 2 of a 5-step SLL
        mode   = 3'd0;
        ins    = 8'h33;
        amount = 4'd5;
        bin    = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_data", 32'(shifted_out), 32'h00);
        check("mid_carry", 32'(carry_out), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("mid_no_done", 32'(done_cnt), 32'd0);

        // Back-to-back: second start issued in the DONE cycle
        run_op(3'd1, 8'h3C, 4'd2, 1'b0, -1);
        check("b2b1_data", 32'(shifted_out), 32'h0F);
        check("b2b1_done", 32'(done), 32'd1);
        mode   = 3'd2;
        ins    = 8'h81;
        amount = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_gap", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        tick();
        check("b2b2_done", 32'(done), 32'd1);
        check("b2b2_data", 32'(shifted_out), 32'hC0);
        check("b2b2_carry", 32'(carry_out), 32'd1);

        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Track any cycle where busy and done are both high
    always @(negedge clk) begin
        if (busy && done) overlap++;
    end

endmodule
